// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
// Contents: loader FSM state enum, stream framing constants and the
// checksum helper used by imem_loader.
package loader_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned LEN_BYTES  = 2;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned LEN_W      = LEN_BYTES * BYTE_W;
    localparam int unsigned WORD_W     = WORD_BYTES * BYTE_W;
    localparam int unsigned IDX_W      = $clog2(WORD_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } loader_state_e;

    // True when adding the final byte brings the 8-bit running sum to zero.
    function automatic logic csum_ok(input logic [BYTE_W-1:0] sum,
                                     input logic [BYTE_W-1:0] b);
        logic [BYTE_W-1:0] total;
        total = BYTE_W'(sum + b);
        return (total == '0);
    endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Assembles four stream bytes into one little-endian 32-bit word.
// Ports:
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   clear_i        drop any partially assembled word and restart at byte 0
//   valid_i        a byte is presented on byte_i this cycle
//   byte_i         stream byte
//   word_c_o       assembled word, meaningful while word_valid_c_o is high
//   word_valid_c_o high in the cycle the fourth byte of a word arrives
module byte_word_packer
    import loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_c_o,
    output logic              word_valid_c_o
);

    localparam int unsigned LOW_W = WORD_W - BYTE_W;

    logic [LOW_W-1:0] low_q;
    logic [IDX_W-1:0] idx_q;

    // Bytes enter at the top and move down, so the first byte ends up in [7:0].
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            low_q <= '0;
            idx_q <= '0;
        end else if (valid_i) begin
            low_q <= {byte_i, low_q[LOW_W-1:BYTE_W]};
            idx_q <= IDX_W'(idx_q + 1'b1);
        end
    end

    // The fourth byte completes the word directly; the caller registers it.
    assign word_c_o       = {byte_i, low_q};
    assign word_valid_c_o = valid_i && (idx_q == IDX_W'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader for the instruction memory write port.
// Stream: LEN (2 bytes LE word count N), N little-endian 32-bit words,
// one checksum byte making the 8-bit sum of all stream bytes zero.
// Holds the core stalled while loading; reports done or err.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 begin a load (honoured in IDLE, DONE, ERR)
//   byte_valid/byte_data  source byte handshake; byte_ready is the accept
//   imem_we/addr/wdata    one-cycle write strobe, word address, word data
//   core_hold             stalls fetch while high
//   done, err             load completed good / load rejected (levels)
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    // One extra bit so a full-depth load can count past the last address.
    localparam int unsigned CNT_W = ADDR_W + 1;

    loader_state_e     state_q;
    logic [LEN_W-1:0]  len_q;
    logic [CNT_W-1:0]  wcnt_q;
    logic [BYTE_W-1:0] sum_q;

    logic              byte_ready_q;
    logic              imem_we_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [WORD_W-1:0] imem_wdata_q;
    logic              core_hold_q;
    logic              done_q;
    logic              err_q;

    logic              xfer_c;
    logic              start_ok_c;
    logic              pk_valid_c;
    logic [WORD_W-1:0] pk_word_c;
    logic              pk_word_valid_c;
    logic              last_word_c;
    logic [LEN_W-1:0]  len_d;
    logic [BYTE_W-1:0] sum_d;

    assign xfer_c     = byte_valid && byte_ready_q;
    assign start_ok_c = start && ((state_q == ST_IDLE) || (state_q == ST_DONE)
                                  || (state_q == ST_ERR));
    assign pk_valid_c = xfer_c && (state_q == ST_DATA);
    assign len_d      = {byte_data, len_q[BYTE_W-1:0]};
    assign sum_d      = BYTE_W'(sum_q + byte_data);
    // The word being completed now is index wcnt_q; it is the last one at N-1.
    assign last_word_c = ((32'(wcnt_q) + 32'd1) == 32'(len_q));

    byte_word_packer u_packer (
        .clk_i          (clk),
        .rst_i          (rst),
        .clear_i        (start_ok_c),
        .valid_i        (pk_valid_c),
        .byte_i         (byte_data),
        .word_c_o       (pk_word_c),
        .word_valid_c_o (pk_word_valid_c)
    );

    // Loader FSM with counters, running checksum and memory-port registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            wcnt_q       <= '0;
            sum_q        <= '0;
            byte_ready_q <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_hold_q  <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            imem_we_q <= 1'b0;
            if (xfer_c) begin
                sum_q <= sum_d;
            end

            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start_ok_c) begin
                        state_q      <= ST_LEN_LO;
                        len_q        <= '0;
                        wcnt_q       <= '0;
                        sum_q        <= '0;
                        byte_ready_q <= 1'b1;
                        core_hold_q  <= 1'b1;
                        done_q       <= 1'b0;
                        err_q        <= 1'b0;
                    end
                end

                ST_LEN_LO: begin
                    if (xfer_c) begin
                        len_q[BYTE_W-1:0] <= byte_data;
                        state_q           <= ST_LEN_HI;
                    end
                end

                ST_LEN_HI: begin
                    if (xfer_c) begin
                        len_q <= len_d;
                        if (32'(len_d) > DEPTH) begin
                            // Image cannot fit: reject before touching memory.
                            state_q      <= ST_ERR;
                            byte_ready_q <= 1'b0;
                            err_q        <= 1'b1;
                        end else if (len_d == '0) begin
                            state_q <= ST_CSUM;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end
                end

                ST_DATA: begin
                    if (pk_word_valid_c) begin
                        imem_we_q    <= 1'b1;
                        imem_addr_q  <= wcnt_q[ADDR_W-1:0];
                        imem_wdata_q <= pk_word_c;
                        wcnt_q       <= CNT_W'(wcnt_q + 1'b1);
                        if (last_word_c) begin
                            state_q <= ST_CSUM;
                        end
                    end
                end

                ST_CSUM: begin
                    if (xfer_c) begin
                        byte_ready_q <= 1'b0;
                        if (csum_ok(sum_q, byte_data)) begin
                            state_q     <= ST_DONE;
                            done_q      <= 1'b1;
                            core_hold_q <= 1'b0;
                        end else begin
                            // Hold stays high so a half-loaded image never runs.
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q      <= ST_IDLE;
                    byte_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready = byte_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_hold  = core_hold_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed loads from the test plan
// plus randomized images checked against a stream/memory reference model.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    typedef logic [7:0]  bq_t [$];
    typedef logic [31:0] wq_t [$];

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'h00;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_hold;
    logic              done;
    logic              err;

    int total = 0;
    int bad   = 0;

    logic [ADDR_W-1:0] wr_addr_q [$];
    logic [31:0]       wr_data_q [$];

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Record every memory write, sampled away from the active edge.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_we"},    32'(imem_we),    32'd0);
        chk({tag, "_addr"},  32'(imem_addr),  32'd0);
        chk({tag, "_wdata"}, imem_wdata,      32'd0);
        chk({tag, "_hold"},  32'(core_hold),  32'd0);
        chk({tag, "_done"},  32'(done),       32'd0);
        chk({tag, "_err"},   32'(err),        32'd0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1; start = 1'b0; byte_valid = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Model: frame a word list as LEN, LE payload and a zero-sum checksum byte.
    function automatic bq_t build(input wq_t w, input logic [15:0] n, input bit corrupt);
        bq_t s;
        int sum;
        logic [31:0] word;
        logic [7:0] cs;
        s.push_back(n[7:0]);
        s.push_back(n[15:8]);
        foreach (w[i]) begin
            word = w[i];
            for (int k = 0; k < 4; k++) s.push_back(word[8*k +: 8]);
        end
        sum = 0;
        foreach (s[i]) sum += int'(s[i]);
        cs = 8'((256 - (sum % 256)) % 256);
        if (corrupt) cs = 8'(cs + 8'($urandom_range(1, 255)));
        s.push_back(cs);
        return s;
    endfunction

    // Offer bytes in order; mode 0 = always valid, 1 = every other cycle, 2 = random.
    task automatic send(input bq_t s, input int mode, output int cyc);
        int idx;
        int budget;
        logic v;
        idx = 0;
        cyc = 0;
        budget = 20 * s.size() + 20;
        while (idx < s.size() && cyc < budget) begin
            @(negedge clk);
            case (mode)
                0:       v = 1'b1;
                1:       v = ((cyc % 2) == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            byte_valid = v;
            byte_data  = v ? s[idx] : 8'($urandom);
            if (v && byte_ready) idx++;
            cyc++;
        end
        @(negedge clk);
        byte_valid = 1'b0;
        chk("stream_consumed", 32'(idx), 32'(s.size()));
    endtask

    task automatic chk_writes(input string tag, input wq_t exp_w);
        chk({tag, "_nwr"}, 32'(wr_addr_q.size()), 32'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < wr_addr_q.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 32'(wr_addr_q[i]), 32'(i));
            chk($sformatf("%s_data%0d", tag, i), wr_data_q[i], exp_w[i]);
        end
        if (exp_w.size() > 0) begin
            chk({tag, "_addr_held"}, 32'(imem_addr), 32'(exp_w.size() - 1));
            chk({tag, "_data_held"}, imem_wdata, exp_w[exp_w.size() - 1]);
        end
    endtask

    task automatic run_bytes(input string tag, input bq_t s, input int mode,
                             input wq_t exp_w, input bit exp_ok);
        int cyc;
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        chk({tag, "_hold_rise"},  32'(core_hold),  32'd1);
        chk({tag, "_ready_rise"}, 32'(byte_ready), 32'd1);
        chk({tag, "_done_clr"},   32'(done),       32'd0);
        chk({tag, "_err_clr"},    32'(err),        32'd0);
        send(s, mode, cyc);
        if (mode == 0) chk({tag, "_no_bubble"}, 32'(cyc), 32'(s.size()));
        chk({tag, "_done"},  32'(done),      32'(exp_ok));
        chk({tag, "_err"},   32'(err),       32'(!exp_ok));
        chk({tag, "_hold"},  32'(core_hold), 32'(!exp_ok));
        chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
        repeat (2) @(negedge clk);
        chk_writes(tag, exp_w);
    endtask

    initial begin
        bq_t s;
        wq_t w;
        int cyc;
        int n;
        bit corrupt;

        // Reset held for two cycles.
        do_reset(2);
        chk_reset_vals("reset");

        // Single word, back-to-back bytes.
        s = {8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h1C};
        w.delete(); w.push_back(32'h00500093);
        run_bytes("single", s, 0, w, 1'b1);

        // Three words with byte_valid toggling.
        w.delete();
        w.push_back(32'h00000013); w.push_back(32'h00100093); w.push_back(32'hFFFFFFFF);
        s = build(w, 16'd3, 1'b0);
        run_bytes("three", s, 1, w, 1'b1);

        // Bad checksum: write still lands, load rejected.
        s = {8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h1D};
        w.delete(); w.push_back(32'h00500093);
        run_bytes("badsum", s, 0, w, 1'b0);

        // Length overflow: N = 257 rejected right after LEN_HI.
        s = {8'h01, 8'h01};
        w.delete();
        run_bytes("ovf", s, 0, w, 1'b0);

        // Empty image.
        s = {8'h00, 8'h00, 8'h00};
        w.delete();
        run_bytes("empty", s, 0, w, 1'b1);

        // Reset after two payload bytes, then a clean load.
        wr_addr_q.delete(); wr_data_q.delete();
        pulse_start();
        s = {8'h01, 8'h00, 8'hAA, 8'hBB};
        send(s, 0, cyc);
        do_reset(1);
        chk_reset_vals("midrst");
        chk("midrst_nwr", 32'(wr_addr_q.size()), 32'd0);
        w.delete(); w.push_back(32'hDEADBEEF);
        s = build(w, 16'd1, 1'b0);
        run_bytes("postrst", s, 0, w, 1'b1);

        // start during DATA is ignored; the load continues intact.
        wr_addr_q.delete(); wr_data_q.delete();
        pulse_start();
        s = {8'h01, 8'h00, 8'h13, 8'h00};
        send(s, 0, cyc);
        pulse_start();
        chk("busy_start_ready", 32'(byte_ready), 32'd1);
        chk("busy_start_hold",  32'(core_hold),  32'd1);
        s = {8'h00, 8'h00, 8'hEC};
        send(s, 0, cyc);
        chk("busy_start_done", 32'(done), 32'd1);
        chk("busy_start_err",  32'(err),  32'd0);
        repeat (2) @(negedge clk);
        w.delete(); w.push_back(32'h00000013);
        chk_writes("busy_start", w);

        // Randomized images with random valid gaps and occasional bad checksums.
        for (int t = 0; t < 8; t++) begin
            n = $urandom_range(1, 6);
            corrupt = ($urandom_range(0, 3) == 0);
            w.delete();
            for (int i = 0; i < n; i++) w.push_back($urandom);
            s = build(w, 16'(n), corrupt);
            run_bytes($sformatf("rand%0d", t), s, 2, w, !corrupt);
        end

        // Full-depth image: last write at the top address.
        w.delete();
        for (int i = 0; i < DEPTH; i++) w.push_back($urandom);
        s = build(w, 16'(DEPTH), 1'b0);
        run_bytes("full", s, 0, w, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader that writes instructions into the pipeline's instruction memory through its write port. It holds the core stalled while it loads.
- It sits between a host-side byte source (UART receiver, JTAG bridge or bench driver) and the instruction memory write port.
- It drives a hold line that keeps the five-stage core from fetching while a load is in progress.
- It replaces the simulation-only hex preload with a synthesizable path, and reports completion or a checksum/length error.

## Interface
Parameters:
- ADDR_W, 8, instruction memory word-address width; depth = 2**ADDR_W words.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- byte_valid  input  1  source has a byte on byte_data.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle; a transfer occurs when byte_valid && byte_ready.
- imem_we  output  1  one-cycle instruction memory write strobe.
- imem_addr  output  ADDR_W  word address for the write.
- imem_wdata  output  32  instruction word for the write.
- core_hold  output  1  stalls the core (PC and fetch frozen) while high.
- done  output  1  level; load completed with a good checksum.
- err  output  1  level; load rejected.

## Operation
Stream format, in order:
- LEN: 2 bytes, 16-bit word count N, little-endian.
- Payload: N×4 bytes. Each word is little-endian; the first byte is bits [7:0].
- CSUM: 1 byte, chosen so that the 8-bit sum of all stream bytes, including CSUM, is 0x00.

State machine: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
- IDLE/DONE/ERR + start → LEN_LO.
  - Clear done, err, word counter, byte index and running sum.
  - Assert core_hold.
- LEN_LO --xfer--> LEN_HI.
- LEN_HI --xfer--> the next state depends on N:
  - N > 2**ADDR_W → ERR, with no writes.
  - N == 0 → CSUM.
  - Otherwise → DATA.
- DATA: shift in bytes, with byte index 0..3.
  - On the 4th transfer, the assembled word is registered.
  - The next cycle shows imem_we=1 with imem_addr = word count, and the word count then increments.
  - After word N-1 → CSUM.
- CSUM --xfer--> DONE if (running sum + byte) mod 256 == 0, else ERR.
- DONE: done=1, core_hold=0.
- ERR: err=1, core_hold stays 1 until the next start or rst.

Other rules:
- byte_ready is 1 exactly in LEN_LO, LEN_HI, DATA and CSUM.
- Every transferred byte, including LEN, is added to the 8-bit running sum, which wraps mod 256.
- start in any busy state is ignored.
- A byte_valid outside the ready states is not consumed.

## Timing
- Reset values: byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_hold=0, done=0, err=0, state=IDLE.
  - core_hold=0 at reset lets an image preloaded in simulation run without a loader pass.
- Throughput: one byte per cycle when byte_valid is held high; no bubbles.
- Write latency: imem_we pulses exactly 1 cycle after the word's 4th byte transfer.
- imem_addr and imem_wdata are held stable until the next write.
- The write pulse may coincide with byte 0 of the next word, or with the CSUM transfer; both proceed.
- done/err assert in the cycle after the CSUM transfer (or the LEN_HI transfer for length overflow).
- core_hold drops in that same cycle on DONE.
- core_hold rises in the cycle after start.
- N == 2**ADDR_W is legal: the last write goes to address 2**ADDR_W-1, and the counter wrap is never used for a write.
- rst mid-load: everything returns to reset values next cycle.
  - Memory words already written stay written.
  - Any partially assembled word is discarded.

## Structure
- Shared package `loader_pkg`:
  - State enum `loader_state_e`.
  - Constants LEN_BYTES=2, WORD_BYTES=4.
- One natural sub-module, `byte_word_packer`:
  - Shifts 4 bytes into a 32-bit little-endian word.
  - Emits a one-cycle word_valid.
  - Has a clear input.
- Top module: FSM, counters, checksum and the memory-port registers.

## Test plan
- Reset: hold rst 2 cycles → all outputs 0, byte_ready=0.
- Single word: start, then bytes 01 00 93 00 50 00 1C streamed back-to-back → one imem_we with addr 0x00, wdata 0x00500093; then done=1, err=0, core_hold=0.
- Back-pressure free: N=3, words 0x00000013, 0x00100093, 0xFFFFFFFF with byte_valid toggling every other cycle, plus the correct CSUM → writes at addrs 0, 1, 2 with those values; done=1.
- Bad checksum: the single-word stream with CSUM 0x1D → the write to addr 0 still occurs; err=1, done=0, core_hold=1.
- Length overflow (ADDR_W=8): LEN bytes 01 01 (N=257) → err=1 right after LEN_HI; no imem_we; byte_ready=0.
- Edge/abort cases:
  - N=0: stream 00 00 00 → done=1 with no writes.
  - Reset after 2 payload bytes, then a full good load → only the good load's writes; done=1.
  - start pulsed during DATA → ignored.
